// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: FSM states, parity modes and
// legal word-length constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'b000,
    PAR_ODD   = 3'b001,
    PAR_EVEN  = 3'b010,
    PAR_MARK  = 3'b011,
    PAR_SPACE = 3'b100
  } parity_e;

  localparam logic [3:0] WL5 = 4'd5;
  localparam logic [3:0] WL6 = 4'd6;
  localparam logic [3:0] WL7 = 4'd7;
  localparam logic [3:0] WL8 = 4'd8;
  localparam logic [3:0] WL9 = 4'd9;

  // Unlisted parity codes fall back to no parity bit.
  function automatic parity_e decode_parity(input logic [2:0] code);
    case (code)
      3'b001:  return PAR_ODD;
      3'b010:  return PAR_EVEN;
      3'b011:  return PAR_MARK;
      3'b100:  return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts baud_tick pulses and flags the OS-th tick of the
// current bit. clear restarts the period on every state entry.
module uart_bit_timer #(
  parameter int unsigned OS = 16
) (
  input  logic bclk,
  input  logic rstn,
  input  logic baud_tick,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = (OS > 1) ? $clog2(OS) : 1;
  localparam logic [CW-1:0] LAST = CW'(OS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = baud_tick && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (baud_tick) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge bclk or posedge rstn) begin
    if (rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmit engine: one character per valid/ready handshake, programmable
// word length, parity, stop bits and bit order, plus a line-break command.
module uart_tx_gen
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OS     = 16
) (
  input  logic              bclk,
  input  logic              rstn,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [3:0]        frame_size,
  input  logic [2:0]        parity_type,
  input  logic              stop2,
  input  logic              msb_first,
  input  logic              tx_break,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic [3:0]  WMAX = 4'(DATA_W);
  localparam int unsigned IW   = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]        fsize_q, fsize_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  parity_e           par_q, par_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              brk_q, brk_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic              bit_end;
  logic              tmr_clear;
  logic [3:0]        fsize_eff;
  logic [DATA_W-1:0] din_masked, din_rev;
  logic              par_calc;

  uart_bit_timer #(.OS(OS)) u_timer (
    .bclk      (bclk),
    .rstn      (rstn),
    .baud_tick (baud_tick),
    .clear     (tmr_clear),
    .bit_end   (bit_end)
  );

  // MSB-first words are bit-reversed within the active width at load time,
  // so the DATA state always shifts out bit 0.
  always_comb begin
    int unsigned fs_i;
    logic [IW-1:0] idx;
    fsize_eff  = (frame_size >= WL5 && frame_size <= WMAX) ? frame_size : WMAX;
    fs_i       = 32'(fsize_eff);
    din_masked = '0;
    din_rev    = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < fs_i) begin
        idx           = IW'(fs_i - 1 - i);
        din_masked[i] = din[i];
        din_rev[i]    = din[idx];
      end
    end
    case (decode_parity(parity_type))
      PAR_ODD:  par_calc = ~^din_masked;
      PAR_EVEN: par_calc = ^din_masked;
      PAR_MARK: par_calc = 1'b1;
      default:  par_calc = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    fsize_d    = fsize_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    brk_d      = brk_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_break) begin
          state_d = ST_BREAK;
        end else if (din_valid) begin
          state_d    = ST_START;
          shreg_d    = msb_first ? din_rev : din_masked;
          fsize_d    = fsize_eff;
          par_d      = decode_parity(parity_type);
          par_bit_d  = par_calc;
          stop2_d    = stop2;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          brk_d      = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == fsize_q - 4'd1) begin
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            state_d    = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = !brk_q;
          end
        end
      end
      ST_BREAK: begin
        if (!tx_break) begin
          state_d    = ST_STOP;
          stop2_d    = stop2;
          stop_cnt_d = 1'b0;
          brk_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_bit_q;
      ST_BREAK:  tx_d = 1'b0;
      default:   tx_d = 1'b1;
    endcase

    tmr_clear = (state_q == ST_IDLE) || (state_d != state_q);
  end

  always_ff @(posedge bclk or posedge rstn) begin
    if (rstn) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      fsize_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= PAR_NONE;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      brk_q      <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      fsize_q    <= fsize_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      brk_q      <= brk_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx        = tx_q;
  assign tx_done   = done_q;
  assign tx_busy   = (state_q != ST_IDLE);
  assign din_ready = (state_q == ST_IDLE) && !tx_break;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Bench for uart_tx_gen: frame-level reference model checked every cycle,
// directed frames with literal bit sequences, then randomized traffic.
module tb_uart_tx_gen;

  localparam int OS_T = 4;

  logic       bclk = 1'b0;
  logic       rstn = 1'b1;
  logic       baud_tick = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [3:0] frame_size = 4'd8;
  logic [2:0] parity_type = '0;
  logic       stop2 = 1'b0;
  logic       msb_first = 1'b0;
  logic       tx_break = 1'b0;
  logic       tx, tx_busy, tx_done;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;

  uart_tx_gen #(.DATA_W(8), .OS(OS_T)) dut (
    .bclk        (bclk),
    .rstn        (rstn),
    .baud_tick   (baud_tick),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .frame_size  (frame_size),
    .parity_type (parity_type),
    .stop2       (stop2),
    .msb_first   (msb_first),
    .tx_break    (tx_break),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  always #5 bclk = ~bclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
  endtask

  // Reference model: whole-frame bit list built at accept, indexed by ticks seen.
  int         m_mode;   // 0 idle, 1 frame, 2 break, 3 post-break stop
  int         m_ticks, m_len, m_fs, m_ones, m_k;
  int         m_bits[16];
  logic [7:0] m_word;
  logic       e_done;

  always @(posedge bclk or posedge rstn) begin
    if (rstn) begin
      m_mode = 0; m_ticks = 0; m_len = 1; e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      case (m_mode)
        0: begin
          if (tx_break) m_mode = 2;
          else if (din_valid) begin
            m_fs   = (frame_size >= 5 && frame_size <= 8) ? int'(frame_size) : 8;
            m_word = din & 8'((1 << m_fs) - 1);
            m_ones = $countones(m_word);
            m_k = 0;
            m_bits[m_k++] = 0;
            for (int i = 0; i < m_fs; i++)
              m_bits[m_k++] = msb_first ? int'(m_word[m_fs-1-i]) : int'(m_word[i]);
            case (parity_type)
              3'b001: m_bits[m_k++] = (m_ones % 2 == 0) ? 1 : 0;
              3'b010: m_bits[m_k++] = m_ones % 2;
              3'b011: m_bits[m_k++] = 1;
              3'b100: m_bits[m_k++] = 0;
              default: ;
            endcase
            m_bits[m_k++] = 1;
            if (stop2) m_bits[m_k++] = 1;
            m_len = m_k; m_ticks = 0; m_mode = 1;
          end
        end
        1: if (baud_tick) begin
          m_ticks++;
          if (m_ticks == m_len * OS_T) begin m_mode = 0; e_done = 1'b1; end
        end
        2: if (!tx_break) begin m_mode = 3; m_ticks = 0; m_len = stop2 ? 2 : 1; end
        default: if (baud_tick) begin
          m_ticks++;
          if (m_ticks == m_len * OS_T) m_mode = 0;
        end
      endcase
    end
  end

  always @(posedge bclk) begin
    logic e_tx;
    #1;
    case (m_mode)
      0: e_tx = 1'b1;
      1: e_tx = m_bits[m_ticks / OS_T][0];
      2: e_tx = 1'b0;
      default: e_tx = 1'b1;
    endcase
    check("model_tx", tx, e_tx);
    check("model_busy", tx_busy, m_mode != 0);
    check("model_done", tx_done, e_done);
    check("model_ready", din_ready, (m_mode == 0) && !tx_break);
    if (tx_done) done_cnt++;
  end

  task automatic run_frame(input logic [7:0] d, input logic [3:0] fs, input logic [2:0] pt,
                           input logic s2, input logic msb, input logic chg,
                           input logic [15:0] exp_seq, input int n, input string nm);
    logic [15:0] got;
    int d0;
    @(negedge bclk);
    din = d; frame_size = fs; parity_type = pt; stop2 = s2; msb_first = msb;
    din_valid = 1'b1; baud_tick = 1'b1; tx_break = 1'b0;
    d0 = done_cnt;
    @(posedge bclk);
    @(negedge bclk);
    din_valid = 1'b0;
    if (chg) begin din = ~d; parity_type = pt ^ 3'b011; end
    got = '0;
    for (int c = 0; c < n * OS_T; c++) begin
      if (c % OS_T == 2) got[c / OS_T] = tx;
      @(negedge bclk);
    end
    check({nm, "_seq"}, got, exp_seq);
    check({nm, "_done"}, tx_done, 1'b1);
    check({nm, "_ready"}, din_ready, 1'b1);
    check({nm, "_done_cnt"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    int brk_ctr;
    repeat (3) @(negedge bclk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_ready", din_ready, 1'b1);
    tx_break = 1'b1; #1;
    check("rst_ready_brk", din_ready, 1'b0);
    tx_break = 1'b0;
    @(negedge bclk); rstn = 1'b0;
    repeat (2) @(negedge bclk);

    run_frame(8'hA5, 4'd8, 3'b000, 1'b0, 1'b0, 1'b0, 16'h034A, 10, "a5_lsb");
    run_frame(8'hFF, 4'd5, 3'b001, 1'b0, 1'b0, 1'b0, 16'h00BE, 8, "fs5_odd");
    run_frame(8'h41, 4'd7, 3'b010, 1'b1, 1'b1, 1'b0, 16'h0682, 11, "msb7_even");
    run_frame(8'h0F, 4'd8, 3'b010, 1'b0, 1'b0, 1'b1, 16'h041E, 11, "latched");

    // Break in IDLE beats a pending request.
    @(negedge bclk);
    tx_break = 1'b1; din_valid = 1'b1; din = 8'h55; baud_tick = 1'b1; stop2 = 1'b0;
    d0 = done_cnt;
    @(negedge bclk);
    check("brk_ready", din_ready, 1'b0);
    check("brk_tx", tx, 1'b0);
    check("brk_busy", tx_busy, 1'b1);
    repeat (6) @(negedge bclk);
    check("brk_tx_hold", tx, 1'b0);
    tx_break = 1'b0; din_valid = 1'b0;
    @(negedge bclk);
    check("brk_stop_tx", tx, 1'b1);
    check("brk_stop_busy", tx_busy, 1'b1);
    repeat (3) @(negedge bclk);
    check("brk_stop_busy_end", tx_busy, 1'b1);
    @(negedge bclk);
    check("brk_idle", tx_busy, 1'b0);
    check("brk_no_done", done_cnt - d0, 0);

    // Reset in the middle of DATA.
    @(negedge bclk);
    din = 8'hA5; frame_size = 4'd8; parity_type = 3'b000; msb_first = 1'b0;
    din_valid = 1'b1; baud_tick = 1'b1;
    d0 = done_cnt;
    @(posedge bclk);
    @(negedge bclk); din_valid = 1'b0;
    repeat (10) @(negedge bclk);
    check("mid_tx_low", tx, 1'b0);
    #2 rstn = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_done", tx_done, 1'b0);
    @(negedge bclk); rstn = 1'b0;
    repeat (2) @(negedge bclk);
    check("mid_rst_no_done", done_cnt - d0, 0);
    run_frame(8'hA5, 4'd8, 3'b000, 1'b0, 1'b0, 1'b0, 16'h034A, 10, "post_rst");

    // Randomized traffic against the model.
    brk_ctr = 0;
    for (int cyc = 0; cyc < 15000; cyc++) begin
      @(negedge bclk);
      rstn        = ($urandom_range(0, 2999) == 0);
      baud_tick   = ($urandom_range(0, 2) != 0);
      din         = 8'($urandom);
      din_valid   = ($urandom_range(0, 3) != 0);
      frame_size  = 4'($urandom_range(0, 15));
      parity_type = 3'($urandom_range(0, 7));
      stop2       = 1'($urandom);
      msb_first   = 1'($urandom);
      if (brk_ctr > 0) brk_ctr--;
      else if ($urandom_range(0, 299) == 0) brk_ctr = $urandom_range(1, 40);
      tx_break = (brk_ctr > 0);
    end
    @(negedge bclk);
    rstn = 1'b0; din_valid = 1'b0; tx_break = 1'b0;
    repeat (2) @(negedge bclk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
